// File: rtl/score_pkg.sv
// score_pkg: shared types and helpers for the score controller.
//   game_state_t : 2-bit game FSM encoding (IDLE=0, RUN=1, PAUSE=2, OVER=3)
//   bcd_t        : one BCD digit
//   bcd4_t       : four BCD digits, index 0 = ones
//   BCD_MAX      : largest legal BCD digit value
//   BCD4_ZERO    : all-zero four-digit value
//   bcd4_gt()    : numeric "a > b" on two four-digit BCD values
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  typedef logic [3:0] bcd_t;
  typedef bcd_t bcd4_t [4];

  localparam bcd_t  BCD_MAX   = 4'd9;
  localparam bcd4_t BCD4_ZERO = '{4'd0, 4'd0, 4'd0, 4'd0};

  // Scan from the most significant digit; the first differing digit decides.
  function automatic logic bcd4_gt(input bcd4_t a, input bcd4_t b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        gt      = (a[i] > b[i]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_add_sat4.sv
// bcd_add_sat4: combinational four-digit BCD adder with saturation.
//   a   in  bcd4_t     augend, four BCD digits (index 0 = ones)
//   add in  7 bits     binary addend, 0..100
//   sum out bcd4_t     a + add, clamped to 9999
module bcd_add_sat4
  import score_pkg::*;
(
  input  bcd4_t      a,
  input  logic [6:0] add,
  output bcd4_t      sum
);

  bcd4_t      add_bcd;
  bcd4_t      raw_sum;
  logic [4:0] digit_sum;
  logic       carry;

  always_comb begin
    // The addend never exceeds 100, so it spans at most three digits.
    add_bcd[0] = 4'(add % 7'd10);
    add_bcd[1] = 4'((add / 7'd10) % 7'd10);
    add_bcd[2] = 4'(add / 7'd100);
    add_bcd[3] = 4'd0;

    carry     = 1'b0;
    digit_sum = 5'd0;
    raw_sum   = BCD4_ZERO;
    for (int i = 0; i < 4; i++) begin
      digit_sum = {1'b0, a[i]} + {1'b0, add_bcd[i]} + {4'd0, carry};
      if (digit_sum > 5'd9) begin
        raw_sum[i] = 4'(digit_sum - 5'd10);
        carry      = 1'b1;
      end else begin
        raw_sum[i] = digit_sum[3:0];
        carry      = 1'b0;
      end
    end

    // A carry out of the thousands digit means the true sum passed 9999.
    for (int i = 0; i < 4; i++) begin
      sum[i] = carry ? BCD_MAX : raw_sum[i];
    end
  end

endmodule

// File: rtl/score_controller.sv
// score_controller: game-level sequencer for the score datapath.
//   Clk         in   1  system clock
//   Reset       in   1  synchronous reset, active low
//   start       in   1  start/restart request (rising edge)
//   pause       in   1  pause toggle (rising edge)
//   hit         in   1  player collision (rising edge)
//   bonus       in   1  bonus pickup (rising edge)
//   score0..3   out  4  current score BCD digits, score0 = ones
//   hi0..3      out  4  high-score BCD digits
//   game_state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3
//   running     out  1  high while game_state is RUN
module score_controller
  import score_pkg::*;
#(
  parameter int TICK_DIV  = 25_000_000,
  parameter int BONUS_PTS = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       bonus,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [3:0] hi0,
  output logic [3:0] hi1,
  output logic [3:0] hi2,
  output logic [3:0] hi3,
  output logic [1:0] game_state,
  output logic       running
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  game_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bcd4_t            score_q, score_d;
  bcd4_t            hi_q, hi_d;

  // Input history for edge detection: {start, pause, hit, bonus}.
  logic [3:0] hist_q, hist_d;
  logic [3:0] evt;
  logic       evt_start, evt_pause, evt_hit, evt_bonus;

  logic       tick;
  logic [6:0] add_bin;
  bcd4_t      score_sum;

  assign hist_d    = {start, pause, hit, bonus};
  assign evt       = hist_d & ~hist_q;
  assign evt_start = evt[3];
  assign evt_pause = evt[2];
  assign evt_hit   = evt[1];
  assign evt_bonus = evt[0];

  // The prescaler is only nonzero-running in RUN, so tick is only
  // acted on from the RUN branch below.
  assign tick    = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign add_bin = {6'd0, tick} + (evt_bonus ? 7'(BONUS_PTS) : 7'd0);

  bcd_add_sat4 u_add (
    .a   (score_q),
    .add (add_bin),
    .sum (score_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    hi_d    = hi_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (evt_start) begin
          state_d = RUN;
          score_d = BCD4_ZERO;
        end
      end

      RUN: begin
        if (evt_hit) begin
          // A collision freezes the score: this cycle's tick/bonus is dropped.
          state_d = OVER;
          cnt_d   = '0;
          if (bcd4_gt(score_q, hi_q)) begin
            hi_d = score_q;
          end
        end else begin
          cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
          score_d = score_sum;
          if (evt_pause) begin
            state_d = PAUSE;
          end
        end
      end

      PAUSE: begin
        // Prescaler holds so the interrupted tick period resumes where it left off.
        if (evt_pause) begin
          state_d = RUN;
        end
      end

      OVER: begin
        cnt_d = '0;
        if (evt_start) begin
          state_d = RUN;
          score_d = BCD4_ZERO;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      score_q <= BCD4_ZERO;
      hi_q    <= BCD4_ZERO;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      hist_q  <= hist_d;
    end
  end

  assign score0     = score_q[0];
  assign score1     = score_q[1];
  assign score2     = score_q[2];
  assign score3     = score_q[3];
  assign hi0        = hi_q[0];
  assign hi1        = hi_q[1];
  assign hi2        = hi_q[2];
  assign hi3        = hi_q[3];
  assign game_state = state_q;
  assign running    = (state_q == RUN);

endmodule

// File: tb/tb_score_controller.sv
// tb_score_controller: self-checking bench for score_controller and its
// bcd_add_sat4 sub-module. A table of adder vectors is checked first, then
// the controller is driven cycle by cycle against a decimal reference model
// through an expected-value queue, with extra hand-written checks at the
// interesting points of each game scenario.
module tb_score_controller;
  import score_pkg::*;

  localparam int TD = 4;
  localparam int BP = 10;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       hit = 1'b0;
  logic       bonus = 1'b0;
  logic [3:0] score0, score1, score2, score3;
  logic [3:0] hi0, hi1, hi2, hi3;
  logic [1:0] game_state;
  logic       running;

  bcd4_t      tb_a;
  logic [6:0] tb_add;
  bcd4_t      tb_sum;

  int n_checks = 0;
  int n_fail   = 0;

  score_controller #(.TICK_DIV(TD), .BONUS_PTS(BP)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .pause      (pause),
    .hit        (hit),
    .bonus      (bonus),
    .score0     (score0),
    .score1     (score1),
    .score2     (score2),
    .score3     (score3),
    .hi0        (hi0),
    .hi1        (hi1),
    .hi2        (hi2),
    .hi3        (hi3),
    .game_state (game_state),
    .running    (running)
  );

  bcd_add_sat4 u_add_ut (
    .a   (tb_a),
    .add (tb_add),
    .sum (tb_sum)
  );

  always #5 Clk = ~Clk;

  wire [15:0] score_w = {score3, score2, score1, score0};
  wire [15:0] hi_w    = {hi3, hi2, hi1, hi0};

  // ---------------- reference model (decimal integers) ----------------
  int m_state = 0;
  int m_score = 0;
  int m_hi    = 0;
  int m_cnt   = 0;
  bit m_sq = 0, m_pq = 0, m_hq = 0, m_bq = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input bit r, input bit s, input bit p, input bit h, input bit b);
    bit es, ep, eh, eb, tk;
    int sum;
    if (!r) begin
      m_state = 0; m_score = 0; m_hi = 0; m_cnt = 0;
      m_sq = 0; m_pq = 0; m_hq = 0; m_bq = 0;
    end else begin
      es = s && !m_sq; ep = p && !m_pq; eh = h && !m_hq; eb = b && !m_bq;
      case (m_state)
        0: if (es) begin m_state = 1; m_score = 0; m_cnt = 0; end
        1: begin
          if (eh) begin
            if (m_score > m_hi) m_hi = m_score;
            m_state = 3;
            m_cnt   = 0;
          end else begin
            tk    = (m_cnt == TD - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            sum   = m_score + (tk ? 1 : 0) + (eb ? BP : 0);
            m_score = (sum > 9999) ? 9999 : sum;
            if (ep) m_state = 2;
          end
        end
        2: if (ep) m_state = 1;
        default: if (es) begin m_state = 1; m_score = 0; m_cnt = 0; end
      endcase
      m_sq = s; m_pq = p; m_hq = h; m_bq = b;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    string tag;
    int    st;
    int    score;
    int    hi;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the model's prediction, then compare
  // the popped prediction against the registered outputs after the edge.
  task automatic step(input bit r, input bit s, input bit p, input bit h, input bit b,
                      input string tag);
    exp_t e;
    Reset = r; start = s; pause = p; hit = h; bonus = b;
    model_step(r, s, p, h, b);
    e.tag = tag; e.st = m_state; e.score = m_score; e.hi = m_hi;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "/state"},   32'(game_state), 32'(e.st));
    chk({e.tag, "/running"}, 32'(running),    32'(e.st == 1));
    chk({e.tag, "/score"},   32'(score_w),    32'(to_bcd(e.score)));
    chk({e.tag, "/hi"},      32'(hi_w),       32'(to_bcd(e.hi)));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, tag);
  endtask

  // Bonus pulses bring the score close, then ticks finish the climb, so the
  // target is always reached by a tick (prescaler at 0 afterwards).
  task automatic run_until(input int target, input string tag);
    int budget;
    budget = 0;
    while ((m_score + 13 <= target) && (budget < 2000)) begin
      step(1, 0, 0, 0, 1, tag);
      step(1, 0, 0, 0, 0, tag);
      budget++;
    end
    budget = 0;
    while ((m_score != target) && (budget < 200)) begin
      step(1, 0, 0, 0, 0, tag);
      budget++;
    end
    if (m_score != target) begin
      n_fail++;
      $display("FAIL %s: cycle budget expired, model score %0d target %0d", tag, m_score, target);
    end
  endtask

  // ---------------- adder vectors ----------------
  typedef struct {
    logic [15:0] a;
    int          add;
    logic [15:0] sum;
  } add_vec_t;

  localparam int NV = 15;
  add_vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int paused_score;
    logic [15:0] got16;

    vecs[0]  = '{16'h0000,   0, 16'h0000};
    vecs[1]  = '{16'h0000,   1, 16'h0001};
    vecs[2]  = '{16'h0009,   1, 16'h0010};
    vecs[3]  = '{16'h0099,   1, 16'h0100};
    vecs[4]  = '{16'h0999,   1, 16'h1000};
    vecs[5]  = '{16'h0089,  11, 16'h0100};
    vecs[6]  = '{16'h9995,  10, 16'h9999};
    vecs[7]  = '{16'h9999,   1, 16'h9999};
    vecs[8]  = '{16'h9989,  10, 16'h9999};
    vecs[9]  = '{16'h9990,   9, 16'h9999};
    vecs[10] = '{16'h1234, 100, 16'h1334};
    vecs[11] = '{16'h0950, 100, 16'h1050};
    vecs[12] = '{16'h9899, 100, 16'h9999};
    vecs[13] = '{16'h4567,  89, 16'h4656};
    vecs[14] = '{16'h9900,  99, 16'h9999};

    for (int i = 0; i < NV; i++) begin
      for (int d = 0; d < 4; d++) tb_a[d] = vecs[i].a[d*4 +: 4];
      tb_add = 7'(vecs[i].add);
      #1;
      got16 = {tb_sum[3], tb_sum[2], tb_sum[1], tb_sum[0]};
      $display("adder %04h + %0d -> %04h", vecs[i].a, vecs[i].add, got16);
      chk($sformatf("adder[%0d]", i), 32'(got16), 32'(vecs[i].sum));
    end

    // Reset, then start: score ticks every TD run cycles.
    step(0, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, "reset");
    chk("reset_state", 32'(game_state), 32'd0);
    chk("reset_score", 32'(score_w), 32'h0);
    step(1, 1, 0, 0, 0, "start");
    chk("start_run", 32'(game_state), 32'd1);
    idle(4, "count");
    chk("first_tick", 32'(score_w), 32'h0001);
    idle(16, "count");
    chk("twenty_cycles", 32'(score_w), 32'h0005);

    // Pause with prescaler at 2; tick follows one run cycle after resume.
    for (int i = 0; i < 8 && m_cnt != 2; i++) step(1, 0, 0, 0, 0, "to_cnt2");
    step(1, 0, 1, 0, 0, "pause_on");
    paused_score = m_score;
    step(1, 0, 0, 0, 0, "paused");
    idle(50, "paused");
    chk("pause_state", 32'(game_state), 32'd2);
    chk("pause_frozen", 32'(score_w), 32'(to_bcd(paused_score)));
    step(1, 0, 1, 0, 0, "resume");
    chk("resume_state", 32'(game_state), 32'd1);
    chk("resume_no_tick", 32'(score_w), 32'(to_bcd(paused_score)));
    step(1, 0, 0, 0, 0, "resume_tick");
    chk("resume_tick", 32'(score_w), 32'(to_bcd(paused_score + 1)));

    // hit and pause together at 42: hit wins, hi captures 42.
    run_until(42, "to42");
    step(1, 0, 1, 1, 0, "hit_pause");
    chk("hit_over", 32'(game_state), 32'd3);
    chk("hit_score", 32'(score_w), 32'h0042);
    chk("hit_hi", 32'(hi_w), 32'h0042);
    idle(3, "over");
    step(1, 1, 0, 0, 0, "restart");
    chk("restart_score", 32'(score_w), 32'h0000);
    chk("restart_hi", 32'(hi_w), 32'h0042);
    step(1, 0, 0, 0, 0, "run2");
    run_until(30, "to30");
    step(1, 0, 0, 1, 0, "hit30");
    chk("hit30_state", 32'(game_state), 32'd3);
    chk("hit30_hi_kept", 32'(hi_w), 32'h0042);

    // Bonus coinciding with a tick at 89 -> 100.
    step(1, 1, 0, 0, 0, "restart3");
    step(1, 0, 0, 0, 0, "run3");
    run_until(79, "to79");
    step(1, 0, 0, 0, 1, "bonus89");
    step(1, 0, 0, 0, 0, "wait89");
    step(1, 0, 0, 0, 0, "wait89");
    chk("score89", 32'(score_w), 32'h0089);
    step(1, 0, 0, 0, 1, "bonus_tick");
    chk("carry100", 32'(score_w), 32'h0100);
    step(1, 0, 0, 0, 0, "run3");

    // Saturation at 9999.
    run_until(9995, "to9995");
    chk("score9995", 32'(score_w), 32'h9995);
    step(1, 0, 0, 0, 1, "bonus_sat");
    chk("sat9999", 32'(score_w), 32'h9999);
    step(1, 0, 0, 0, 0, "sat");
    idle(20, "sat");
    chk("sat_hold", 32'(score_w), 32'h9999);

    // Reset mid-run with start held high.
    step(1, 1, 0, 0, 0, "start_in_run");
    chk("start_ignored", 32'(game_state), 32'd1);
    step(0, 1, 0, 0, 0, "mid_reset");
    step(0, 1, 0, 0, 0, "mid_reset");
    chk("mid_reset_state", 32'(game_state), 32'd0);
    chk("mid_reset_score", 32'(score_w), 32'h0);
    chk("mid_reset_hi", 32'(hi_w), 32'h0);
    chk("mid_reset_running", 32'(running), 32'd0);
    step(1, 1, 0, 0, 0, "release");
    chk("release_edge", 32'(game_state), 32'd1);
    step(1, 1, 0, 0, 0, "held");
    step(1, 1, 0, 0, 0, "held");
    step(1, 1, 0, 0, 0, "held");
    step(1, 1, 0, 1, 0, "hit_on_tick");
    chk("hit_drops_tick", 32'(score_w), 32'h0000);
    idle(0, "none");
    step(1, 1, 0, 0, 0, "held_over");
    step(1, 1, 0, 0, 0, "held_over");
    chk("level_ignored", 32'(game_state), 32'd3);
    step(1, 0, 0, 0, 0, "drop");
    step(1, 1, 0, 0, 0, "rise");
    chk("rise_run", 32'(game_state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
